// File: rtl/sample_streamer_pkg.sv
// Shared types and constants for the sample streamer: state encoding, datapath widths
// and the burst-length legality check.
package sample_streamer_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned ADDR_W          = 12;
    localparam int unsigned MEM_DEPTH       = 4096;
    localparam int unsigned LEN_W           = 13;
    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StPrefetch,
        StSend,
        StWaitRsp,
        StDone
    } state_e;

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/sample_rsp_monitor.sv
// Response capture for the sample streamer: beat counter, running sum, and the idle
// counter that aborts a run when the core never answers.
module sample_rsp_monitor
    import sample_streamer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              capture_en,
    input  logic              wait_en,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic [LEN_W-1:0]  rsp_count,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              timeout,
    output logic              rsp_end,
    output logic              timeout_hit
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              beat;

    assign beat        = capture_en && rsp_valid;
    assign rsp_end     = wait_en && !rsp_valid && (count_q != '0);
    assign timeout_hit = wait_en && !rsp_valid && (count_q == '0) &&
                         (idle_q == IdleW'(TIMEOUT - 1));

    always_comb begin
        count_d   = count_q;
        sum_d     = sum_q;
        timeout_d = timeout_q;
        if (clear) begin
            count_d   = '0;
            sum_d     = '0;
            timeout_d = 1'b0;
        end else begin
            if (beat) begin
                sum_d = sum_q + rsp_data;
                if (count_q != LEN_W'(MEM_DEPTH)) begin
                    count_d = count_q + LEN_W'(1);
                end
            end
            if (timeout_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Counts silent cycles only while waiting; the FSM leaves WAIT_RSP on a hit, so it
    // never runs past TIMEOUT-1.
    always_comb begin
        idle_d = '0;
        if (wait_en && !rsp_valid) begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            sum_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            sum_q     <= sum_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_count = count_q;
    assign rsp_sum   = sum_q;
    assign timeout   = timeout_q;

endmodule

// File: rtl/sample_streamer.sv
// Streams a burst of words from a registered-read sample SRAM to a core as one gap-free
// valid run, then collects the core's response beats.
module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [LEN_W-1:0]  rsp_count,
    output logic [DATA_W-1:0] rsp_sum
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              rd_valid_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              accept;
    logic              last_addr;
    logic              rsp_end;
    logic              timeout_hit;

    assign last_addr = (mem_addr_q == ADDR_W'(len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && len_legal(length)) begin
                    accept  = 1'b1;
                    state_d = StPrefetch;
                end
            end
            StPrefetch: state_d = StSend;
            // The last beat is on the output when nothing further is in the read pipe.
            StSend: begin
                if (out_valid_q && !rd_valid_q) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (rsp_end || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        mem_re_d   = mem_re_q;
        mem_addr_d = mem_addr_q;
        if (accept) begin
            len_d      = length;
            mem_re_d   = 1'b1;
            mem_addr_d = '0;
        end else if (mem_re_q) begin
            if (last_addr) begin
                mem_re_d = 1'b0;
            end else begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
        end
    end

    assign out_data_d = rd_valid_q ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            rd_valid_q  <= mem_re_q;
            out_valid_q <= rd_valid_q;
            out_data_q  <= out_data_d;
        end
    end

    sample_rsp_monitor #(
        .TIMEOUT(TIMEOUT)
    ) u_rsp_monitor (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .capture_en ((state_q == StSend) || (state_q == StWaitRsp)),
        .wait_en    (state_q == StWaitRsp),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_count  (rsp_count),
        .rsp_sum    (rsp_sum),
        .timeout    (timeout),
        .rsp_end    (rsp_end),
        .timeout_hit(timeout_hit)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench for sample_streamer: table of bursts plus hand-written corner
// sequences; a scoreboard queue holds the expected transmit words.
module tb_sample_streamer;
    import sample_streamer_pkg::*;

    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  length = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              rsp_valid = 1'b0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [LEN_W-1:0]  rsp_count;
    logic [DATA_W-1:0] rsp_sum;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int rises = 0;
    int done_cnt = 0;
    int max_addr = 0;
    int first_ov_cyc = 0;
    int start_edge = 0;
    logic prev_ov = 1'b0;

    sample_streamer #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .length   (length),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_data (out_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .rsp_count(rsp_count),
        .rsp_sum  (rsp_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard and stream observers, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            beats++;
            if (!prev_ov) begin
                rises++;
                first_ov_cyc = cyc;
            end
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("beat_data", out_data, exp_q.pop_front());
        end else begin
            check("idle_data_zero", out_data, 0);
        end
        prev_ov = out_valid;
        if (mem_re && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (done) done_cnt++;
    end

    task automatic run(input string tag, input int len, input int nrsp,
                       input logic [15:0] base, input logic [15:0] step, input bit acc,
                       input int ecount, input logic [15:0] esum, input bit eto,
                       input bit repulse);
        int seen;
        int w0;
        int exp_lat;
        bit got;
        bit any_busy;
        beats = 0;
        rises = 0;
        done_cnt = 0;
        max_addr = 0;
        if (acc) for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        length = LEN_W'(len);
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        length = '0;
        check({tag, "_busy_c1"}, busy, acc);
        if (!acc) begin
            any_busy = busy;
            repeat (8) begin
                @(negedge clk);
                any_busy |= busy;
            end
            check({tag, "_rej_busy"}, any_busy, 0);
            check({tag, "_rej_beats"}, beats, 0);
            check({tag, "_rej_done"}, done_cnt, 0);
            check({tag, "_rej_count"}, rsp_count, ecount);
            check({tag, "_rej_sum"}, rsp_sum, esum);
            check({tag, "_rej_timeout"}, timeout, eto);
            return;
        end
        seen = 0;
        for (int k = 0; k < len + 8 && seen < len; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) seen++;
            if (repulse && seen == 1 && out_valid) begin
                start = 1'b1;
                length = LEN_W'(2);
            end
        end
        start = 1'b0;
        check({tag, "_burst_len"}, seen, len);
        @(negedge clk);
        w0 = cyc;
        check({tag, "_first_beat_lat"}, first_ov_cyc - start_edge, 2);
        for (int i = 0; i < nrsp; i++) begin
            rsp_valid = 1'b1;
            rsp_data = base + 16'(step * i);
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        rsp_data = '0;
        got = 1'b0;
        for (int k = 0; k < TO + 8; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        exp_lat = (nrsp == 0) ? TO : nrsp + 1;
        check({tag, "_done_lat"}, cyc - w0, exp_lat);
        check({tag, "_count"}, rsp_count, ecount);
        check({tag, "_sum"}, rsp_sum, esum);
        check({tag, "_timeout"}, timeout, eto);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_runs"}, rises, 1);
        check({tag, "_beats"}, beats, len);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_count_hold"}, rsp_count, ecount);
    endtask

    typedef struct {
        int          len;
        int          nrsp;
        logic [15:0] base;
        logic [15:0] step;
        bit          acc;
        int          ecount;
        logic [15:0] esum;
        bit          eto;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int seen;
        vecs[0] = '{4,    4, 16'd10,    16'd10,    1'b1, 4, 16'd100,    1'b0};
        vecs[1] = '{1,    1, 16'hFFFF,  16'd0,     1'b1, 1, 16'hFFFF,   1'b0};
        vecs[2] = '{7,    3, 16'h8000,  16'h8000,  1'b1, 3, 16'h0000,   1'b0};
        vecs[3] = '{2,    0, 16'd0,     16'd0,     1'b1, 0, 16'd0,      1'b1};
        vecs[4] = '{0,    2, 16'd1,     16'd1,     1'b0, 0, 16'd0,      1'b1};
        vecs[5] = '{5000, 2, 16'd1,     16'd1,     1'b0, 0, 16'd0,      1'b1};
        vecs[6] = '{16,   5, 16'd3,     16'd7,     1'b1, 5, 16'd85,     1'b0};
        for (int k = 0; k < MEM_DEPTH; k++) mem[k] = 16'(k + 1);

        repeat (2) @(negedge clk);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", rsp_count, 0);
        check("rst_sum", rsp_sum, 0);

        for (int v = 0; v < 7; v++) begin
            run($sformatf("vec%0d", v), vecs[v].len, vecs[v].nrsp, vecs[v].base,
                vecs[v].step, vecs[v].acc, vecs[v].ecount, vecs[v].esum, vecs[v].eto, 1'b0);
        end

        for (int k = 0; k < MEM_DEPTH; k++) mem[k] = 16'(k);
        run("full", 4096, 2, 16'd1, 16'd1, 1'b1, 2, 16'd3, 1'b0, 1'b0);
        check("full_max_addr", max_addr, 4095);

        // Asynchronous reset in the middle of an 8-word burst.
        beats = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
        @(negedge clk);
        start = 1'b1;
        length = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 16 && seen < 2; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rstmid_beats", seen, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_mem_re", mem_re, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_count", rsp_count, 0);
        exp_q.delete();
        run("after_rst", 3, 2, 16'd5, 16'd5, 1'b1, 2, 16'd15, 1'b0, 1'b0);

        run("repulse", 6, 3, 16'd100, 16'd1, 1'b1, 3, 16'd303, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
